// File: rtl/rst_sequencer.sv
// Reset/clock-enable sequencer: stretches the board reset, releases domains in
// ascending order, and re-runs the sequence after a drained software reset.
module rst_sequencer #(
  parameter int N_DOMAINS   = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sw_rst_req,
  output logic                 sw_rst_ack,
  output logic [N_DOMAINS-1:0] dom_rst,
  output logic [N_DOMAINS-1:0] dom_clk_en,
  output logic                 seq_done,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]     HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]     GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]     DRAIN_END = CNT_W'(N_DOMAINS);
  localparam logic [N_DOMAINS-1:0] ONE       = N_DOMAINS'(1);

  state_t               state_q, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [3:0]           idx, idx_n;
  logic [N_DOMAINS-1:0] rst_n_v, en_n;
  logic                 done_n, ack_n, req_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HOLD;
      cnt        <= '0;
      idx        <= '0;
      dom_rst    <= '1;
      dom_clk_en <= '1;
      seq_done   <= 1'b0;
      sw_rst_ack <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      dom_rst    <= rst_n_v;
      dom_clk_en <= en_n;
      seq_done   <= done_n;
      sw_rst_ack <= ack_n;
      req_q      <= sw_rst_req;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt;
    idx_n   = idx;
    rst_n_v = dom_rst;
    en_n    = dom_clk_en;
    done_n  = seq_done;
    ack_n   = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_n   = '0;
          idx_n   = 4'd1;
          rst_n_v = dom_rst & ~ONE;
          if (N_DOMAINS == 1) begin
            state_n = S_RUN;
            done_n  = 1'b1;
          end else begin
            state_n = S_RELEASE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          idx_n   = idx + 4'd1;
          rst_n_v = dom_rst & ~(ONE << idx);
          if (idx == 4'(N_DOMAINS - 1)) begin
            state_n = S_RUN;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        // Only a fresh rising edge of the request starts a drain
        if (sw_rst_req && !req_q) begin
          state_n              = S_DRAIN;
          done_n               = 1'b0;
          en_n[N_DOMAINS-1]    = 1'b0;
          cnt_n                = CNT_W'(1);
        end
      end
      S_DRAIN: begin
        // cnt holds how many enables have already been dropped
        if (cnt == DRAIN_END) begin
          state_n = S_HOLD;
          cnt_n   = '0;
          rst_n_v = '1;
          en_n    = '1;
          ack_n   = 1'b1;
        end else begin
          for (int i = 0; i < N_DOMAINS; i++) begin
            if (i == N_DOMAINS - 1 - int'(cnt)) en_n[i] = 1'b0;
          end
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = S_HOLD;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: default configuration plus a minimal
// single-domain instance with one-cycle hold and gap.
module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1, req = 1'b0;
  logic       ack, done;
  logic [2:0] drst, den;
  logic [1:0] st;

  logic       rst1 = 1'b1, req1 = 1'b0;
  logic       ack1, done1;
  logic [0:0] drst1, den1;
  logic [1:0] st1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  rst_sequencer dut (
    .clk(clk), .rst(rst), .sw_rst_req(req), .sw_rst_ack(ack),
    .dom_rst(drst), .dom_clk_en(den), .seq_done(done), .state(st)
  );

  rst_sequencer #(.N_DOMAINS(1), .HOLD_CYCLES(1), .GAP_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst1), .sw_rst_req(req1), .sw_rst_ack(ack1),
    .dom_rst(drst1), .dom_clk_en(den1), .seq_done(done1), .state(st1)
  );

  // Expected default-configuration outputs e edges after the last reset edge
  function automatic logic [2:0] exp_rst(int e);
    if (e < 16)      return 3'b111;
    else if (e < 24) return 3'b110;
    else if (e < 32) return 3'b100;
    else             return 3'b000;
  endfunction

  function automatic logic [1:0] exp_st(int e);
    if (e < 16)      return 2'd0;
    else if (e < 32) return 2'd1;
    else             return 2'd2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (10) step();
    chk_cnt++;
    if ({drst, den, done, ack, st} !== {3'b111, 3'b111, 1'b0, 1'b0, 2'd0})
      $display("FAIL reset_vals got rst=%b en=%b done=%b ack=%b st=%0d want 111 111 0 0 0",
               drst, den, done, ack, st);
    else pass_cnt++;
  endtask

  task automatic test_release();
    int bad = 0;
    rst = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      step();
      if (drst !== exp_rst(e) || done !== (e >= 32) || st !== exp_st(e) || ack !== 1'b0) begin
        bad++;
        $display("FAIL release_e%0d got rst=%b done=%b st=%0d ack=%b want rst=%b done=%b st=%0d",
                 e, drst, done, st, ack, exp_rst(e), (e >= 32), exp_st(e));
      end
      chk_cnt++;
      if (bad == 0) pass_cnt++;
      bad = 0;
    end
  endtask

  task automatic test_sw_reset();
    logic [2:0] en_exp [3] = '{3'b011, 3'b001, 3'b000};
    req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      req = 1'b0;
      chk_cnt++;
      if (den !== en_exp[k] || drst !== 3'b000 || done !== 1'b0 || st !== 2'd3 || ack !== 1'b0)
        $display("FAIL drain_d%0d got en=%b rst=%b done=%b st=%0d ack=%b want en=%b rst=000 done=0 st=3 ack=0",
                 k, den, drst, done, st, ack, en_exp[k]);
      else pass_cnt++;
    end
    step();
    chk_cnt++;
    if (drst !== 3'b111 || den !== 3'b111 || ack !== 1'b1 || st !== 2'd0)
      $display("FAIL drain_d3 got rst=%b en=%b ack=%b st=%0d want 111 111 1 0", drst, den, ack, st);
    else pass_cnt++;
    for (int e = 1; e <= 32; e++) begin
      step();
      chk_cnt++;
      if (drst !== exp_rst(e) || done !== (e >= 32) || ack !== 1'b0 || den !== 3'b111)
        $display("FAIL resequence_e%0d got rst=%b done=%b ack=%b en=%b want rst=%b done=%b ack=0 en=111",
                 e, drst, done, ack, den, exp_rst(e), (e >= 32));
      else pass_cnt++;
    end
  endtask

  task automatic test_hold_req();
    int acks = 0;
    int drains_late = 0;
    req = 1'b1;
    for (int k = 0; k < 3 + 32 + 20; k++) begin
      step();
      if (ack === 1'b1) acks++;
      if (k > 3 && st === 2'd3) drains_late++;
    end
    chk_cnt++;
    if (acks !== 1) $display("FAIL held_req_acks got %0d want 1", acks);
    else pass_cnt++;
    chk_cnt++;
    if (drains_late !== 0 || st !== 2'd2)
      $display("FAIL held_req_retrigger got drains=%0d st=%0d want 0 2", drains_late, st);
    else pass_cnt++;
    req = 1'b0;
    step();
    req = 1'b1;
    step();
    chk_cnt++;
    if (st !== 2'd3 || den !== 3'b011)
      $display("FAIL req_rearm got st=%0d en=%b want 3 011", st, den);
    else pass_cnt++;
    req = 1'b0;
    repeat (3 + 32) step();
    chk_cnt++;
    if (st !== 2'd2 || done !== 1'b1 || drst !== 3'b000)
      $display("FAIL rearm_complete got st=%0d done=%b rst=%b want 2 1 000", st, done, drst);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    int acks = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (17) step();
    chk_cnt++;
    if (drst !== 3'b110 || st !== 2'd1)
      $display("FAIL mid_release_pre got rst=%b st=%0d want 110 1", drst, st);
    else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cnt++;
    if (drst !== 3'b111 || den !== 3'b111 || st !== 2'd0 || ack !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_release got rst=%b en=%b st=%0d ack=%b done=%b want 111 111 0 0 0",
               drst, den, st, ack, done);
    else pass_cnt++;
    for (int e = 1; e <= 32; e++) begin
      step();
      if (e == 15 || e == 16 || e == 24 || e == 32) begin
        chk_cnt++;
        if (drst !== exp_rst(e) || done !== (e >= 32))
          $display("FAIL restart_release_e%0d got rst=%b done=%b want rst=%b done=%b",
                   e, drst, done, exp_rst(e), (e >= 32));
        else pass_cnt++;
      end
    end
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    chk_cnt++;
    if (den !== 3'b001 || st !== 2'd3)
      $display("FAIL mid_drain_pre got en=%b st=%0d want 001 3", den, st);
    else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cnt++;
    if (drst !== 3'b111 || den !== 3'b111 || st !== 2'd0 || ack !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_drain got rst=%b en=%b st=%0d ack=%b done=%b want 111 111 0 0 0",
               drst, den, st, ack, done);
    else pass_cnt++;
    for (int e = 1; e <= 32; e++) begin
      step();
      if (ack === 1'b1) acks++;
      if (e == 15 || e == 16 || e == 24 || e == 31 || e == 32) begin
        chk_cnt++;
        if (drst !== exp_rst(e) || done !== (e >= 32) || st !== exp_st(e))
          $display("FAIL restart_drain_e%0d got rst=%b done=%b st=%0d want rst=%b done=%b st=%0d",
                   e, drst, done, st, exp_rst(e), (e >= 32), exp_st(e));
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (acks !== 0) $display("FAIL abort_drain_ack got %0d acks want 0", acks);
    else pass_cnt++;
  endtask

  task automatic test_req_ignored();
    int acks = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      req = (e == 5 || e == 20) ? 1'b1 : 1'b0;
      step();
      if (ack === 1'b1) acks++;
      if (e == 15 || e == 16 || e == 23 || e == 24 || e == 32 || e == 40) begin
        chk_cnt++;
        if (drst !== exp_rst(e) || done !== (e >= 32) || st !== exp_st(e))
          $display("FAIL ignored_req_e%0d got rst=%b done=%b st=%0d want rst=%b done=%b st=%0d",
                   e, drst, done, st, exp_rst(e), (e >= 32), exp_st(e));
        else pass_cnt++;
      end
    end
    req = 1'b0;
    chk_cnt++;
    if (acks !== 0 || den !== 3'b111)
      $display("FAIL ignored_req_ack got acks=%0d en=%b want 0 111", acks, den);
    else pass_cnt++;
  endtask

  task automatic test_small();
    rst1 = 1'b1;
    step();
    chk_cnt++;
    if (drst1 !== 1'b1 || den1 !== 1'b1 || done1 !== 1'b0 || st1 !== 2'd0)
      $display("FAIL small_reset got rst=%b en=%b done=%b st=%0d want 1 1 0 0", drst1, den1, done1, st1);
    else pass_cnt++;
    rst1 = 1'b0;
    step();
    chk_cnt++;
    if (drst1 !== 1'b0 || done1 !== 1'b1 || st1 !== 2'd2)
      $display("FAIL small_release got rst=%b done=%b st=%0d want 0 1 2", drst1, done1, st1);
    else pass_cnt++;
    req1 = 1'b1;
    step();
    req1 = 1'b0;
    chk_cnt++;
    if (den1 !== 1'b0 || done1 !== 1'b0 || st1 !== 2'd3 || ack1 !== 1'b0)
      $display("FAIL small_d0 got en=%b done=%b st=%0d ack=%b want 0 0 3 0", den1, done1, st1, ack1);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (drst1 !== 1'b1 || den1 !== 1'b1 || ack1 !== 1'b1 || st1 !== 2'd0)
      $display("FAIL small_d1 got rst=%b en=%b ack=%b st=%0d want 1 1 1 0", drst1, den1, ack1, st1);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (drst1 !== 1'b0 || done1 !== 1'b1 || ack1 !== 1'b0 || st1 !== 2'd2)
      $display("FAIL small_rerun got rst=%b done=%b ack=%b st=%0d want 0 1 0 2", drst1, done1, ack1, st1);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_release();
    test_sw_reset();
    test_hold_req();
    test_rst_mid();
    test_req_ignored();
    test_small();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
